// File: rtl/debug_cmd_decoder.sv
// Debug command decoder: parses opcode/payload byte frames from a UART-style
// receiver, dispatches one command strobe to a debug controller, then replies
// with an echoed opcode byte and, for read commands, 4 bytes of read-back data.
module debug_cmd_decoder #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic [3:0]  debug_fn,
    output logic [31:0] addr,
    output logic [31:0] d_in,
    output logic        out_valid,
    input  logic        ctrlr_busy,
    input  logic [31:0] d_rd,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] FN_NONE   = 4'd0;
    localparam logic [3:0] FN_STATUS = 4'd5;
    localparam logic [3:0] FN_BP_ADD = 4'd6;
    localparam logic [3:0] FN_BP_RM  = 4'd7;
    localparam logic [3:0] FN_MEM_RD = 4'd8;
    localparam logic [3:0] FN_MEM_WR = 4'd9;
    localparam logic [3:0] FN_REG_RD = 4'd10;
    localparam logic [3:0] FN_REG_WR = 4'd11;

    typedef enum logic [2:0] {
        IDLE, RX_ADDR, RX_DATA, DISPATCH, WAIT_CTRL, TX_ACK, TX_DATA
    } state_e;

    function automatic logic fn_valid(input logic [3:0] fn);
        return (fn != FN_NONE) && (fn <= FN_REG_WR);
    endfunction

    function automatic logic fn_has_addr(input logic [3:0] fn);
        return fn inside {FN_BP_ADD, FN_BP_RM, FN_MEM_RD, FN_MEM_WR, FN_REG_RD, FN_REG_WR};
    endfunction

    function automatic logic fn_has_data(input logic [3:0] fn);
        return fn inside {FN_MEM_WR, FN_REG_WR};
    endfunction

    function automatic logic fn_is_read(input logic [3:0] fn);
        return fn inside {FN_MEM_RD, FN_REG_RD, FN_STATUS};
    endfunction

    state_e        state_q, state_d;
    logic [3:0]    fn_q, fn_d;
    logic [7:0]    ack_q, ack_d;       // echoed opcode, or 0xEE on reject
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   din_q, din_d;
    logic [31:0]   reply_q, reply_d;   // read-back data, shifted out MSB first
    logic [1:0]    cnt_q, cnt_d;       // byte index within a 32-bit field
    logic [TW-1:0] tmo_q, tmo_d;       // idle cycles since last accepted byte
    logic          guard_q, guard_d;   // cycle after tx_start: tx_busy not yet valid

    logic          out_valid_c, tx_start_c, frame_err_c;
    logic [7:0]    tx_byte;

    // Next-state, datapath updates and strobes.
    always_comb begin
        state_d     = state_q;
        fn_d        = fn_q;
        ack_d       = ack_q;
        addr_d      = addr_q;
        din_d       = din_q;
        reply_d     = reply_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        out_valid_c = 1'b0;
        tx_start_c  = 1'b0;
        frame_err_c = 1'b0;
        tx_byte     = 8'h00;
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    addr_d = '0;
                    din_d  = '0;
                    cnt_d  = '0;
                    tmo_d  = '0;
                    if (!fn_valid(rx_data[3:0])) begin
                        fn_d        = FN_NONE;
                        ack_d       = 8'hEE;
                        frame_err_c = 1'b1;
                        state_d     = TX_ACK;
                    end else begin
                        fn_d    = rx_data[3:0];
                        ack_d   = rx_data;
                        state_d = fn_has_addr(rx_data[3:0]) ? RX_ADDR : DISPATCH;
                    end
                end
            end
            RX_ADDR, RX_DATA: begin
                if (rx_valid) begin
                    tmo_d = '0;
                    cnt_d = cnt_q + 2'd1;
                    if (state_q == RX_ADDR) addr_d = {addr_q[23:0], rx_data};
                    else                    din_d  = {din_q[23:0], rx_data};
                    if (cnt_q == 2'd3)
                        state_d = (state_q == RX_ADDR && fn_has_data(fn_q)) ? RX_DATA : DISPATCH;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Stalled frame: drop it silently apart from the error pulse.
                    frame_err_c = 1'b1;
                    tmo_d       = '0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            DISPATCH: begin
                if (!ctrlr_busy) begin
                    out_valid_c = 1'b1;
                    state_d     = WAIT_CTRL;
                end
            end
            WAIT_CTRL: begin
                if (!ctrlr_busy) begin
                    reply_d = d_rd;
                    state_d = TX_ACK;
                end
            end
            TX_ACK: begin
                if (!tx_busy && !guard_q) begin
                    tx_start_c = 1'b1;
                    tx_byte    = ack_q;
                    state_d    = fn_is_read(fn_q) ? TX_DATA : IDLE;
                end
            end
            TX_DATA: begin
                if (!tx_busy && !guard_q) begin
                    tx_start_c = 1'b1;
                    tx_byte    = reply_q[31:24];
                    reply_d    = {reply_q[23:0], 8'h00};
                    cnt_d      = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        guard_d = tx_start_c;
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            fn_q    <= FN_NONE;
            ack_q   <= 8'h00;
            addr_q  <= '0;
            din_q   <= '0;
            reply_q <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            guard_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fn_q    <= fn_d;
            ack_q   <= ack_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            reply_q <= reply_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            guard_q <= guard_d;
        end
    end

    // Strobes are suppressed while reset is held so a pending dispatch cannot leak out.
    assign out_valid = out_valid_c & ~reset;
    assign tx_start  = tx_start_c & ~reset;
    assign frame_err = frame_err_c & ~reset;
    assign tx_data   = reset ? 8'h00 : tx_byte;
    assign debug_fn  = fn_q;
    assign addr      = addr_q;
    assign d_in      = din_q;

endmodule

// File: tb/tb_debug_cmd_decoder.sv
// Bench for debug_cmd_decoder: directed frame table, randomized frames against a
// frame-level model, plus timeout and reset sequences.
module tb_debug_cmd_decoder;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [3:0]  debug_fn;
    logic [31:0] addr, d_in;
    logic        out_valid;
    logic        ctrlr_busy;
    logic [31:0] d_rd;
    logic        frame_err;

    logic        ctrl_auto = 1'b1;
    logic        man_busy = 1'b0;
    logic        pre_busy = 1'b0;
    logic        auto_busy;
    logic        tx_active;
    logic [31:0] next_drd = 32'h0;

    assign ctrlr_busy = ctrl_auto ? (auto_busy | pre_busy) : man_busy;

    always #5 clk = ~clk;

    debug_cmd_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .debug_fn(debug_fn), .addr(addr), .d_in(d_in), .out_valid(out_valid),
        .ctrlr_busy(ctrlr_busy), .d_rd(d_rd), .frame_err(frame_err)
    );

    int total = 0, bad = 0, cur_id = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle.
    int          ov_cnt = 0, err_cnt = 0, ov_cyc = 0, err_cyc = 0, excl_viol = 0, guard_viol = 0;
    logic [3:0]  ov_fn;
    logic [31:0] ov_addr, ov_din;
    logic [7:0]  txq[$];
    always @(negedge clk) begin
        if (out_valid) begin
            ov_cnt <= ov_cnt + 1; ov_cyc <= cyc;
            ov_fn <= debug_fn; ov_addr <= addr; ov_din <= d_in;
        end
        if (tx_start) begin
            txq.push_back(tx_data);
            if (tx_active) guard_viol <= guard_viol + 1;
        end
        if (frame_err) begin err_cnt <= err_cnt + 1; err_cyc <= cyc; end
        if (int'(out_valid) + int'(tx_start) + int'(frame_err) > 1) excl_viol <= excl_viol + 1;
    end

    // Transmitter: busy rises only after the guard cycle, then stays up a few cycles.
    initial begin
        tx_busy = 1'b0; tx_active = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                @(posedge clk); #1 tx_active = 1'b1;
                @(posedge clk); #1 tx_busy = 1'b1;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1 tx_busy = 1'b0; tx_active = 1'b0;
            end
        end
    end

    // Controller: after a strobe, optionally busy for a while; d_rd is only
    // meaningful in the cycle busy drops.
    initial begin
        int n;
        auto_busy = 1'b0; d_rd = 32'h0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                n = $urandom_range(0, 3);
                @(posedge clk); #1;
                if (n > 0) begin
                    auto_busy = 1'b1; d_rd = $urandom;
                    repeat (n) begin @(posedge clk); #1; end
                    auto_busy = 1'b0;
                end
                d_rd = next_drd;
                @(posedge clk); #1 d_rd = $urandom;
            end
        end
    end

    typedef struct packed {
        logic [3:0]  n;     // bytes in frame
        logic [71:0] b;     // frame bytes, first at MSB
        logic [31:0] drd;   // controller read-back value
        logic        ov;    // expect a command strobe
        logic [3:0]  fn;
        logic        ca;    // check addr
        logic [31:0] addr;
        logic        cd;    // check d_in
        logic [31:0] din;
        logic        err;
        logic [2:0]  ntx;
        logic [39:0] tx;    // expected reply bytes, first at MSB
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h want=%h", nm, cur_id, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Drives bytes starting now (caller sits just after a posedge); k extra
    // controller-busy cycles are held past the final byte.
    task automatic send(input logic [71:0] b, input int n, input int k, output int last);
        last = cyc;
        for (int i = 0; i < n; i++) begin
            rx_data = b[71 - 8*i -: 8]; rx_valid = 1'b1; last = cyc;
            if (i == n - 1 && k > 0) pre_busy = 1'b1;
            tick();
            rx_valid = 1'b0; rx_data = 8'($urandom);
            if (i < n - 1) repeat ($urandom_range(0, 3)) tick();
        end
        repeat (k) tick();
        pre_busy = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int base_ov, base_err, base_tx, last, w, got_tx;
        base_ov = ov_cnt; base_err = err_cnt; base_tx = txq.size();
        next_drd = v.drd;
        send(v.b, int'(v.n), k, last);
        w = 0;
        while (txq.size() - base_tx < int'(v.ntx) && w < 300) begin tick(); w++; end
        repeat (8) tick();
        chk("strobe_count", ov_cnt - base_ov, 32'(v.ov));
        if (v.ov) begin
            chk("debug_fn", ov_fn, v.fn);
            chk("latency", ov_cyc - last, 1 + k);
            chk("fn_held", debug_fn, v.fn);
            if (v.ca) begin chk("addr", ov_addr, v.addr); chk("addr_held", addr, v.addr); end
            if (v.cd) begin chk("d_in", ov_din, v.din); chk("d_in_held", d_in, v.din); end
        end
        chk("frame_err_count", err_cnt - base_err, 32'(v.err));
        got_tx = txq.size() - base_tx;
        chk("tx_count", got_tx, 32'(v.ntx));
        for (int i = 0; i < int'(v.ntx) && i < got_tx; i++)
            chk("tx_byte", txq[base_tx + i], v.tx[39 - 8*i -: 8]);
    endtask

    function automatic vec_t mk(input logic [3:0] n, input logic [71:0] b, input logic [31:0] drd,
                                input logic ov, input logic [3:0] fn, input logic ca,
                                input logic [31:0] a, input logic cd, input logic [31:0] din,
                                input logic err, input logic [2:0] ntx, input logic [39:0] tx);
        vec_t v;
        v.n = n; v.b = b; v.drd = drd; v.ov = ov; v.fn = fn; v.ca = ca; v.addr = a;
        v.cd = cd; v.din = din; v.err = err; v.ntx = ntx; v.tx = tx;
        return v;
    endfunction

    // Frame-level reference: payload size and reply shape follow from the command code.
    function automatic vec_t model(input logic [7:0] op, input logic [31:0] a,
                                   input logic [31:0] dd, input logic [31:0] drd);
        vec_t v;
        int fn, plen;
        bit ok, rd;
        fn   = int'(op[3:0]);
        ok   = fn >= 1 && fn <= 11;
        plen = (fn == 6 || fn == 7 || fn == 8 || fn == 10) ? 4 : (fn == 9 || fn == 11) ? 8 : 0;
        rd   = fn == 5 || fn == 8 || fn == 10;
        v.n = 4'(1 + plen); v.b = {op, a, dd}; v.drd = drd;
        v.ov = ok; v.fn = op[3:0];
        v.ca = ok && plen >= 4; v.addr = a;
        v.cd = ok && plen == 8; v.din = dd;
        v.err = !ok;
        v.ntx = !ok ? 3'd1 : rd ? 3'd5 : 3'd1;
        v.tx  = !ok ? {8'hEE, 32'h0} : {op, drd};
        return v;
    endfunction

    vec_t tbl[9];

    initial begin
        int base_ov, base_err, base_tx, last, w, k;
        logic [7:0] op;
        tbl[0] = mk(1, {8'h01, 64'h0}, 32'h12345678, 1, 4'h1, 0, 0, 0, 0, 0, 1, {8'h01, 32'h0});
        tbl[1] = mk(5, {8'h08, 32'h12345678, 32'h0}, 32'hCAFEF00D, 1, 4'h8, 1, 32'h12345678, 0, 0, 0, 5, {8'h08, 32'hCAFEF00D});
        tbl[2] = mk(9, {8'h09, 32'h00000010, 32'hDEADBEEF}, 32'h0, 1, 4'h9, 1, 32'h00000010, 1, 32'hDEADBEEF, 0, 1, {8'h09, 32'h0});
        tbl[3] = mk(1, {8'h0C, 64'h0}, 32'h0, 0, 4'h0, 0, 0, 0, 0, 1, 1, {8'hEE, 32'h0});
        tbl[4] = mk(1, {8'h05, 64'h0}, 32'hA5A55A5A, 1, 4'h5, 0, 0, 0, 0, 0, 5, {8'h05, 32'hA5A55A5A});
        tbl[5] = mk(1, {8'h00, 64'h0}, 32'h0, 0, 4'h0, 0, 0, 0, 0, 1, 1, {8'hEE, 32'h0});
        tbl[6] = mk(9, {8'h3B, 32'hFFFFFFFF, 32'h00000001}, 32'h0, 1, 4'hB, 1, 32'hFFFFFFFF, 1, 32'h00000001, 0, 1, {8'h3B, 32'h0});
        tbl[7] = mk(5, {8'h0A, 32'h80000001, 32'h0}, 32'h01020304, 1, 4'hA, 1, 32'h80000001, 0, 0, 0, 5, {8'h0A, 32'h01020304});
        tbl[8] = mk(5, {8'hF7, 32'h0BADF00D, 32'h0}, 32'h0, 1, 4'h7, 1, 32'h0BADF00D, 0, 0, 0, 1, {8'hF7, 32'h0});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_debug_fn", debug_fn, 0); chk("rst_addr", addr, 0); chk("rst_d_in", d_in, 0);
        chk("rst_out_valid", out_valid, 0); chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0); chk("rst_frame_err", frame_err, 0);
        reset = 1'b0;

        // Directed table; first opcode lands in the cycle right after reset release.
        for (int i = 0; i < 9; i++) begin cur_id = i; run_vec(tbl[i], 0); end

        // Randomized frames against the model.
        for (int i = 0; i < 40; i++) begin
            cur_id = 100 + i;
            if ($urandom_range(0, 9) == 0) begin
                k = $urandom_range(0, 4);
                op = {4'($urandom), (k == 0) ? 4'd0 : 4'(k + 11)};
            end else op = {4'($urandom), 4'($urandom_range(1, 11))};
            k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            run_vec(model(op, $urandom, $urandom, $urandom), k);
        end

        // Stalled frame: error exactly TMO idle cycles after the last byte, no reply.
        cur_id = 200;
        base_ov = ov_cnt; base_err = err_cnt; base_tx = txq.size();
        send({8'h06, 8'hAA, 56'h0}, 2, 0, last);
        w = 0;
        while (err_cnt == base_err && w < 40) begin tick(); w++; end
        repeat (4) tick();
        chk("tmo_err_count", err_cnt - base_err, 1);
        chk("tmo_err_cycle", err_cyc - last, TMO);
        chk("tmo_no_strobe", ov_cnt - base_ov, 0);
        chk("tmo_no_tx", txq.size() - base_tx, 0);
        cur_id = 201;
        run_vec(mk(1, {8'h02, 64'h0}, 32'h0, 1, 4'h2, 0, 0, 0, 0, 0, 1, {8'h02, 32'h0}), 0);

        // Reset in the middle of a write frame discards the partial frame.
        cur_id = 202;
        send({8'h09, 8'h11, 8'h22, 48'h0}, 3, 0, last);
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        run_vec(tbl[2], 0);

        // Reset while the dispatch is stalled by a busy controller.
        cur_id = 203;
        ctrl_auto = 1'b0; man_busy = 1'b1;
        base_ov = ov_cnt; base_tx = txq.size(); base_err = err_cnt;
        send({8'h01, 64'h0}, 1, 0, last);
        repeat (25) tick();
        reset = 1'b1;
        repeat (3) tick();
        chk("rst2_debug_fn", debug_fn, 0); chk("rst2_addr", addr, 0); chk("rst2_d_in", d_in, 0);
        chk("rst2_out_valid", out_valid, 0); chk("rst2_tx_start", tx_start, 0);
        chk("rst2_tx_data", tx_data, 0); chk("rst2_frame_err", frame_err, 0);
        reset = 1'b0;
        repeat (22) tick();
        man_busy = 1'b0;
        repeat (20) tick();
        chk("rst2_no_strobe", ov_cnt - base_ov, 0);
        chk("rst2_no_tx", txq.size() - base_tx, 0);
        chk("rst2_no_err", err_cnt - base_err, 0);
        ctrl_auto = 1'b1;

        cur_id = 300;
        chk("strobe_overlap", excl_viol, 0);
        chk("guard_cycle", guard_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
